// File: rtl/pio_in_edge_irq_multi.sv
// rtl/pio_in_edge_irq_multi.sv - multi-channel input PIO with per-channel edge capture and level IRQ
// Optional input debounce filter enabled by defining PIO_DEBOUNCE_EN.
module pio_in_edge_irq_multi #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_MODE   = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_CAP    = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]   sync_out;
  logic [WIDTH-1:0]   filt;
  logic [WIDTH-1:0]   prev_q;
  logic [2*WIDTH-1:0] mode_q, mode_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [WIDTH-1:0]   cap_q, cap_d;
  logic [WIDTH-1:0]   rise, fall, hit;
  logic [31:0]        rdata_q, rdata_d;
  logic               wr_en;
  logic               unused_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [WIDTH-1:0] filt_q;

  // A channel only adopts the synchronised level after it has differed for DEBOUNCE_CYCLES clocks in a row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_out[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          filt_q[i] <= sync_out[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign filt = filt_q;
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYCLES != 0);
  assign filt = sync_out;
`endif

  assign rise  = filt & ~prev_q;
  assign fall  = ~filt & prev_q;
  assign wr_en = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hit[i] = (mode_q[2*i] & rise[i]) | (mode_q[2*i+1] & fall[i]);
    end
  end

  // New edges are OR-ed in after the W1C so a coincident edge keeps the bit set.
  always_comb begin
    mode_d = mode_q;
    mask_d = mask_q;
    cap_d  = cap_q;
    if (wr_en) begin
      case (address)
        ADDR_MODE: mode_d = writedata[2*WIDTH-1:0];
        ADDR_MASK: mask_d = writedata[WIDTH-1:0];
        ADDR_CAP:  cap_d  = cap_q & ~writedata[WIDTH-1:0];
        default:   ;
      endcase
    end
    cap_d = cap_d | hit;
  end

  always_comb begin
    rdata_d = '0;
    case (address)
      ADDR_DATA:   rdata_d[WIDTH-1:0]   = filt;
      ADDR_MODE:   rdata_d[2*WIDTH-1:0] = mode_q;
      ADDR_MASK:   rdata_d[WIDTH-1:0]   = mask_q;
      ADDR_CAP:    rdata_d[WIDTH-1:0]   = cap_q;
      ADDR_STATUS: rdata_d[WIDTH-1:0]   = cap_q & mask_q;
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q  <= '0;
      mode_q  <= '0;
      mask_q  <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
    end else begin
      prev_q  <= filt;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule
